// File: rtl/sync_fifo_pkg.sv
// Shared defaults and elaboration helpers for the single-clock FIFO.
// Sizing rules live here so the top and the storage array agree on them.
package sync_fifo_pkg;

   localparam int FIFO_DEPTH_DEF = 16;
   localparam int FIFO_WIDTH_DEF = 8;

   // The wrap-bit full/empty scheme only works for power-of-two depths.
   function automatic bit fifo_depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array: one write port, one registered read port.
// Only the read register is reset; array contents are left as they are.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int WIDTH = FIFO_WIDTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // rdata holds unless a read is accepted, so the consumer sees a stable word.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer and flag control around sync_fifo_mem.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int WIDTH = FIFO_WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr,
   input  logic [WIDTH-1:0] din,
   input  logic             rd,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH_l    = $clog2(DEPTH);
   localparam int FIFO_PTR_W = DEPTH_l + 1;

   if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [FIFO_PTR_W-1:0] wp;
   logic [FIFO_PTR_W-1:0] rp;
   logic                  wr_acc;
   logic                  rd_acc;

   assign empty = (wp == rp);
   assign full  = (wp[DEPTH_l-1:0] == rp[DEPTH_l-1:0]) &&
                  (wp[DEPTH_l] != rp[DEPTH_l]);

   // Both requests are qualified against the pre-edge flags, so a write into
   // an empty FIFO is never bypassed to the read port in the same cycle.
   assign wr_acc = wr & ~full & ~reset;
   assign rd_acc = rd & ~empty & ~reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (wr_acc) begin
            wp <= wp + FIFO_PTR_W'(1);
         end
         if (rd_acc) begin
            rp <= rp + FIFO_PTR_W'(1);
         end
      end
   end

   sync_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (DEPTH_l)
   ) u_mem (
      .clock (clock),
      .reset (reset),
      .we    (wr_acc),
      .waddr (wp[DEPTH_l-1:0]),
      .wdata (din),
      .re    (rd_acc),
      .raddr (rp[DEPTH_l-1:0]),
      .rdata (dout)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a posedge reference model queues expected
// read words, a negedge monitor pops them and checks dout and the flags.
module tb_sync_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             wr    = 1'b0;
   logic             rd    = 1'b0;
   logic [WIDTH-1:0] din   = '0;
   logic [WIDTH-1:0] dout;
   logic             full;
   logic             empty;

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0] model_q [$];
   logic [WIDTH-1:0] scb_q [$];
   logic [WIDTH-1:0] ref_dout = '0;
   logic [WIDTH-1:0] d [20];
   bit               started = 1'b0;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .wr    (wr),
      .din   (din),
      .rd    (rd),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: qualify requests against pre-edge occupancy.
   always @(posedge clock) begin
      if (reset) begin
         model_q.delete();
         scb_q.delete();
         ref_dout = '0;
         started  = 1'b1;
      end else begin
         int n;
         bit rok, wok;
         n   = model_q.size();
         rok = rd && (n > 0);
         wok = wr && (n < DEPTH);
         if (rok) scb_q.push_back(model_q.pop_front());
         if (wok) model_q.push_back(din);
      end
   end

   // Monitor: a queued word means the DUT must present it now; otherwise hold.
   always @(negedge clock) begin
      if (started) begin
         if (scb_q.size() > 0) ref_dout = scb_q.pop_front();
         check("dout", 32'(dout), 32'(ref_dout));
         check("empty", 32'(empty), 32'(model_q.size() == 0));
         check("full", 32'(full), 32'(model_q.size() == DEPTH));
      end
   end

   task automatic cyc(input bit w, input bit r, input logic [WIDTH-1:0] data);
      @(negedge clock);
      wr  = w;
      rd  = r;
      din = data;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
   endtask

   initial begin
      logic [WIDTH-1:0] saved;

      // Reset held 10 cycles.
      reset = 1'b1;
      idle(10);
      reset = 1'b0;
      idle(1);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);

      // Overfill: 20 writes, last 4 dropped.
      for (int i = 0; i < 20; i++) d[i] = WIDTH'($urandom);
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, d[i]);
      idle(1);
      check("overfill_full", 32'(full), 32'd1);
      check("overfill_empty", 32'(empty), 32'd0);

      // Overdrain: 20 reads, dout holds D15 after the 16th.
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, '0);
      idle(1);
      check("overdrain_empty", 32'(empty), 32'd1);
      check("overdrain_dout", 32'(dout), 32'(d[15]));

      // Wrap-around: 10 in/out then a full 16 in/out across the boundary.
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, WIDTH'(8'h30 + i));
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, '0);
      idle(1);
      check("wrap10_dout", 32'(dout), 32'h39);
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, WIDTH'(8'h50 + i));
      idle(1);
      check("wrap15_full", 32'(full), 32'd0);
      cyc(1'b1, 1'b0, 8'h5f);
      idle(1);
      check("wrap16_full", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, '0);
      idle(1);
      check("wrap16_dout", 32'(dout), 32'h5f);
      check("wrap16_empty", 32'(empty), 32'd1);

      // Simultaneous with 5 stored: occupancy unchanged, order kept.
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, WIDTH'(8'h70 + i));
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, WIDTH'(8'h80 + i));
      idle(1);
      check("sim5_dout", 32'(dout), 32'h82);
      check("sim5_empty", 32'(empty), 32'd0);

      // Simultaneous when full: read taken, write dropped.
      for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, WIDTH'(8'h90 + i));
      idle(1);
      check("simfull_pre", 32'(full), 32'd1);
      cyc(1'b1, 1'b1, 8'hee);
      idle(1);
      check("simfull_dout", 32'(dout), 32'h83);
      check("simfull_full", 32'(full), 32'd0);

      // Drain 15, then simultaneous when empty: write taken, dout unchanged.
      for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, '0);
      idle(1);
      check("drain_dout", 32'(dout), 32'h9a);
      saved = 8'h9a;
      cyc(1'b1, 1'b1, 8'hc5);
      idle(1);
      check("simempty_dout", 32'(dout), 32'(saved));
      check("simempty_empty", 32'(empty), 32'd0);
      cyc(1'b0, 1'b1, '0);
      idle(1);
      check("simempty_read", 32'(dout), 32'hc5);

      // Reset mid-operation with 7 stored.
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, WIDTH'(8'ha0 + i));
      @(negedge clock);
      wr = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("midrst_empty", 32'(empty), 32'd1);
      check("midrst_dout", 32'(dout), 32'd0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0);
      idle(1);
      check("midrst_rd_dout", 32'(dout), 32'd0);
      check("midrst_rd_empty", 32'(empty), 32'd1);

      // Random bursts checked against the model every cycle.
      for (int b = 0; b < 100; b++) begin
         int len, wbias, rbias;
         len   = int'($urandom_range(8, 1));
         wbias = int'($urandom_range(100, 0));
         rbias = int'($urandom_range(100, 0));
         for (int i = 0; i < len; i++)
            cyc(bit'($urandom_range(99, 0) < wbias), bit'($urandom_range(99, 0) < rbias),
                WIDTH'($urandom));
      end
      idle(3);
      check("scb_drained", 32'(scb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
